// File: rtl/systolic_feeder_if.sv
// Operand-load and edge-stream bundle between the register decode, the
// systolic feeder and the multiply array.
interface systolic_feeder_if #(
  parameter int MAX_DIM    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int IDX_W      = $clog2(MAX_DIM)
);
  logic                          wr_en_i;
  logic                          wr_sel_i;
  logic [IDX_W-1:0]              wr_idx_i;
  logic [BUS_WIDTH-1:0]          wr_data_i;
  logic [IDX_W-1:0]              n_dim_i;
  logic [IDX_W-1:0]              k_dim_i;
  logic [IDX_W-1:0]              m_dim_i;
  logic                          start_i;
  logic [MAX_DIM*DATA_WIDTH-1:0] a_o;
  logic [MAX_DIM*DATA_WIDTH-1:0] b_o;
  logic                          valid_o;
  logic                          clr_acc_o;
  logic                          busy_o;
  logic                          done_o;
  logic                          load_err_o;

  modport master (
    output wr_en_i, wr_sel_i, wr_idx_i, wr_data_i,
    output n_dim_i, k_dim_i, m_dim_i, start_i,
    input  a_o, b_o, valid_o, clr_acc_o, busy_o, done_o, load_err_o
  );

  modport slave (
    input  wr_en_i, wr_sel_i, wr_idx_i, wr_data_i,
    input  n_dim_i, k_dim_i, m_dim_i, start_i,
    output a_o, b_o, valid_o, clr_acc_o, busy_o, done_o, load_err_o
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers A rows / B columns and streams them diagonally skewed into the
// west and north edges of an output-stationary systolic array.
module systolic_feeder #(
  parameter int MAX_DIM    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int IDX_W      = $clog2(MAX_DIM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  systolic_feeder_if.slave   bus
);
  localparam int VEC_W = MAX_DIM * DATA_WIDTH;
  localparam int CW    = IDX_W + 2;
  localparam logic [CW-1:0] FEED_TAIL  = CW'(MAX_DIM - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(MAX_DIM - 2);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     t_q, t_d;
  logic [IDX_W-1:0]  n_q, n_d, k_q, k_d, m_q, m_d;

  logic [DATA_WIDTH-1:0] a_buf_q [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] a_buf_d [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_buf_q [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_buf_d [MAX_DIM][MAX_DIM];

  logic [VEC_W-1:0]  a_q, a_d, b_q, b_d;
  logic              valid_q, valid_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;

  logic              start_ok;
  logic              wr_ok;
  logic              idx_in_range;

  assign idx_in_range = (32'(bus.wr_idx_i) < MAX_DIM);

  // Dimensions are taken straight from the inputs on the start cycle so the
  // first FEED beat (registered at that same edge) is already masked.
  always_comb begin
    start_ok   = bus.start_i && (state_q == S_IDLE);
    wr_ok      = bus.wr_en_i && (state_q == S_IDLE) && !bus.start_i;
    state_d    = state_q;
    t_d        = t_q;
    n_d        = n_q;
    k_d        = k_q;
    m_d        = m_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_FEED;
          t_d     = '0;
          n_d     = bus.n_dim_i;
          k_d     = bus.k_dim_i;
          m_d     = bus.m_dim_i;
        end
      end
      S_FEED: begin
        if (t_q == ({2'b00, k_q} + FEED_TAIL)) begin
          state_d = S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + ONE;
        end
      end
      S_DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d    = (state_d == S_FEED) || (state_d == S_DRAIN);
    busy_d     = valid_d;
    clr_d      = start_ok;
    done_d     = (state_d == S_DONE);
    load_err_d = bus.wr_en_i && !wr_ok;
  end

  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_ok && idx_in_range) begin
      for (int k = 0; k < MAX_DIM; k++) begin
        if (!bus.wr_sel_i)
          a_buf_d[bus.wr_idx_i][k] = bus.wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        else
          b_buf_d[bus.wr_idx_i][k] = bus.wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane gi sees element (t - gi) of its row/column: this is the skew.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(gi);
    logic [CW-1:0]         off;
    logic                  in_win;
    logic [DATA_WIDTH-1:0] a_el;
    logic [DATA_WIDTH-1:0] b_el;

    always_comb begin
      off    = t_d - LANE;
      in_win = (state_d == S_FEED) && (t_d >= LANE) && (off <= {2'b00, k_d});
      a_el   = '0;
      b_el   = '0;
      if (in_win && (LANE <= {2'b00, n_d}))
        a_el = a_buf_q[gi][off[IDX_W-1:0]];
      if (in_win && (LANE <= {2'b00, m_d}))
        b_el = b_buf_q[gi][off[IDX_W-1:0]];
    end

    assign a_d[gi*DATA_WIDTH +: DATA_WIDTH] = a_el;
    assign b_d[gi*DATA_WIDTH +: DATA_WIDTH] = b_el;
  end

  if (BUS_WIDTH > VEC_W) begin : g_wide_bus
    logic unused_hi;
    assign unused_hi = ^bus.wr_data_i[BUS_WIDTH-1:VEC_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      valid_q    <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          a_buf_q[r][c] <= '0;
          b_buf_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      n_q        <= n_d;
      k_q        <= k_d;
      m_q        <= m_d;
      a_q        <= a_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
    end
  end

  assign bus.a_o        = a_q;
  assign bus.b_o        = b_q;
  assign bus.valid_o    = valid_q;
  assign bus.clr_acc_o  = clr_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.load_err_o = load_err_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: table-driven skew checks plus
// hand-written sequences for write rejection, start overlap and reset.
module tb_systolic_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if bus_if ();
  systolic_feeder dut (.clk_i(clk), .rst_i(rst), .bus(bus_if));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  f;   // {valid, clr_acc, busy, done, load_err}
  } vec_t;

  localparam logic [4:0] F_IDLE  = 5'b00000;
  localparam logic [4:0] F_FIRST = 5'b11100;
  localparam logic [4:0] F_RUN   = 5'b10100;
  localparam logic [4:0] F_DONE  = 5'b00010;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc, clrs, dones;
  logic [31:0] orab;

  function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f);
    vec_t v;
    v.a = a; v.b = b; v.f = f;
    return v;
  endfunction

  function automatic logic [4:0] flags();
    return {bus_if.valid_o, bus_if.clr_acc_o, bus_if.busy_o, bus_if.done_o, bus_if.load_err_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input logic sel, input logic [1:0] idx, input logic [31:0] data);
    bus_if.wr_en_i   = 1'b1;
    bus_if.wr_sel_i  = sel;
    bus_if.wr_idx_i  = idx;
    bus_if.wr_data_i = data;
    step();
    bus_if.wr_en_i   = 1'b0;
    check($sformatf("write sel%0d idx%0d load_err", sel, idx), 64'(bus_if.load_err_o), 64'd0);
  endtask

  task automatic start_op(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
    bus_if.n_dim_i = n;
    bus_if.k_dim_i = k;
    bus_if.m_dim_i = m;
    bus_if.start_i = 1'b1;
    step();
    bus_if.start_i = 1'b0;
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) step();
      check($sformatf("%s a c%0d", tag, i + 1), 64'(bus_if.a_o), 64'(tbl[i].a));
      check($sformatf("%s b c%0d", tag, i + 1), 64'(bus_if.b_o), 64'(tbl[i].b));
      check($sformatf("%s flags c%0d", tag, i + 1), 64'(flags()), 64'(tbl[i].f));
    end
  endtask

  // Steps until done_o is seen (bounded); cyc stays -1 on timeout.
  task automatic run_to_done(output int c, output int nclr, output logic [31:0] ab);
    c = -1; nclr = 0; ab = '0;
    for (int i = 1; i <= 40; i++) begin
      step();
      nclr += int'(bus_if.clr_acc_o);
      ab |= bus_if.a_o | bus_if.b_o;
      if (bus_if.done_o) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    bus_if.wr_en_i = 0; bus_if.wr_sel_i = 0; bus_if.wr_idx_i = 0; bus_if.wr_data_i = 0;
    bus_if.n_dim_i = 0; bus_if.k_dim_i = 0; bus_if.m_dim_i = 0; bus_if.start_i = 0;
    step(); step();
    check("reset a", 64'(bus_if.a_o), 64'd0);
    check("reset b", 64'(bus_if.b_o), 64'd0);
    check("reset flags", 64'(flags()), 64'(F_IDLE));
    rst = 1'b0;
    step();

    // Identity A, B[k][j] = 4k+j, full 4x4x4
    for (int i = 0; i < 4; i++) write_vec(1'b0, 2'(i), 32'h1 << (8 * i));
    write_vec(1'b1, 2'd0, 32'h0C080400);
    write_vec(1'b1, 2'd1, 32'h0D090501);
    write_vec(1'b1, 2'd2, 32'h0E0A0602);
    write_vec(1'b1, 2'd3, 32'h0F0B0703);
    tbl.delete();
    tbl.push_back(mkv(32'h00000001, 32'h00000000, F_FIRST));
    tbl.push_back(mkv(32'h00000000, 32'h00000104, F_RUN));
    tbl.push_back(mkv(32'h00000100, 32'h00020508, F_RUN));
    tbl.push_back(mkv(32'h00000000, 32'h0306090C, F_RUN));
    tbl.push_back(mkv(32'h00010000, 32'h070A0D00, F_RUN));
    tbl.push_back(mkv(32'h00000000, 32'h0B0E0000, F_RUN));
    tbl.push_back(mkv(32'h01000000, 32'h0F000000, F_RUN));
    for (int i = 0; i < 3; i++) tbl.push_back(mkv(32'h0, 32'h0, F_RUN));
    tbl.push_back(mkv(32'h0, 32'h0, F_DONE));
    start_op(2'd3, 2'd3, 2'd3);
    apply_table("ident");
    step();

    // Dense A, n=2 k=1 m=0: row 3 and columns 1-3 masked
    write_vec(1'b0, 2'd0, 32'h14131211);
    write_vec(1'b0, 2'd1, 32'h24232221);
    write_vec(1'b0, 2'd2, 32'h34333231);
    write_vec(1'b0, 2'd3, 32'h44434241);
    tbl.delete();
    tbl.push_back(mkv(32'h00000011, 32'h00000000, F_FIRST));
    tbl.push_back(mkv(32'h00002112, 32'h00000004, F_RUN));
    tbl.push_back(mkv(32'h00312200, 32'h00000000, F_RUN));
    tbl.push_back(mkv(32'h00320000, 32'h00000000, F_RUN));
    tbl.push_back(mkv(32'h00000000, 32'h00000000, F_RUN));
    for (int i = 0; i < 3; i++) tbl.push_back(mkv(32'h0, 32'h0, F_RUN));
    tbl.push_back(mkv(32'h0, 32'h0, F_DONE));
    start_op(2'd2, 2'd1, 2'd0);
    apply_table("mask");
    step();

    // Write together with start, then write during FEED: both rejected
    bus_if.n_dim_i = 2'd3; bus_if.k_dim_i = 2'd3; bus_if.m_dim_i = 2'd3;
    bus_if.start_i = 1'b1;
    bus_if.wr_en_i = 1'b1; bus_if.wr_sel_i = 1'b0; bus_if.wr_idx_i = 2'd0;
    bus_if.wr_data_i = 32'hDEADBEEF;
    step();
    bus_if.start_i = 1'b0; bus_if.wr_en_i = 1'b0;
    check("wr+start load_err", 64'(bus_if.load_err_o), 64'd1);
    check("wr+start clr_acc", 64'(bus_if.clr_acc_o), 64'd1);
    check("wr+start old a t0", 64'(bus_if.a_o), 64'h00000011);
    step();
    check("load_err single pulse", 64'(bus_if.load_err_o), 64'd0);
    bus_if.wr_en_i = 1'b1; bus_if.wr_sel_i = 1'b1; bus_if.wr_idx_i = 2'd0;
    bus_if.wr_data_i = 32'hFFFFFFFF;
    step();
    bus_if.wr_en_i = 1'b0;
    check("feed write load_err", 64'(bus_if.load_err_o), 64'd1);
    step();
    check("feed write load_err clear", 64'(bus_if.load_err_o), 64'd0);
    run_to_done(cyc, clrs, orab);
    check("feed write done timing", 64'(cyc), 64'd7);
    step();
    start_op(2'd3, 2'd3, 2'd3);
    check("buffer kept a t0", 64'(bus_if.a_o), 64'h00000011);
    step();
    check("buffer kept a t1", 64'(bus_if.a_o), 64'h00002112);
    check("buffer kept b t1", 64'(bus_if.b_o), 64'h00000104);
    run_to_done(cyc, clrs, orab);
    check("rerun done timing", 64'(cyc), 64'd9);
    step();

    // start held through FEED and the done cycle
    bus_if.start_i = 1'b1;
    step();
    check("held start first flags", 64'(flags()), 64'(F_FIRST));
    run_to_done(cyc, clrs, orab);
    check("held start done timing", 64'(cyc), 64'd10);
    check("held start no clr", 64'(clrs), 64'd0);
    step();
    check("no restart on done", 64'(flags()), 64'(F_IDLE));
    step();
    check("restart after idle", 64'(flags()), 64'(F_FIRST));
    bus_if.start_i = 1'b0;
    run_to_done(cyc, clrs, orab);
    check("restart done timing", 64'(cyc), 64'd10);
    step();

    // Reset at FEED t=3 aborts and clears buffers
    start_op(2'd3, 2'd3, 2'd3);
    step(); step(); step();
    check("pre-reset busy", 64'(bus_if.busy_o), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset a", 64'(bus_if.a_o), 64'd0);
    check("mid reset b", 64'(bus_if.b_o), 64'd0);
    check("mid reset flags", 64'(flags()), 64'(F_IDLE));
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      dones += int'(bus_if.done_o);
    end
    check("no done after reset", 64'(dones), 64'd0);
    start_op(2'd3, 2'd3, 2'd3);
    check("post-reset clr", 64'(bus_if.clr_acc_o), 64'd1);
    run_to_done(cyc, clrs, orab);
    check("post-reset done timing", 64'(cyc), 64'd10);
    check("post-reset zero feed", 64'(orab), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
